// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin sharing of the 4-LED bank (D1-D4) and power LED (D5).
// A granted requester shows a static, rotating or blinking pattern for N ticks; otherwise the idle rotation runs.
module led_bank_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int TICK_DIV = 600000,
   parameter int DUR_W    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [4*NUM_REQ-1:0]     req_pattern,
   input  logic [2*NUM_REQ-1:0]     req_mode,
   input  logic [DUR_W*NUM_REQ-1:0] req_dur,
   output logic [3:0]               led,
   output logic                     led_pwr,
   output logic                     busy,
   output logic [1:0]               grant_id
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   typedef enum logic {ST_IDLE, ST_SHOW} state_e;
   typedef enum logic [1:0] {MODE_STATIC, MODE_CW, MODE_CCW, MODE_BLINK} mode_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [3:0]       idle_rot_q, idle_rot_d;
   logic [1:0]       rr_ptr_q, rr_ptr_d;
   logic [1:0]       grant_id_q, grant_id_d;
   logic [3:0]       cur_pat_q, cur_pat_d;
   mode_e            cur_mode_q, cur_mode_d;
   logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
   logic             blank_q, blank_d;

   logic             tick;
   logic             accept;
   logic             win_found;
   logic [1:0]       win_idx;
   logic [1:0]       win_next;
   logic [3:0]       win_pat;
   logic [1:0]       win_mode;
   logic [DUR_W-1:0] win_dur;

   logic [3:0]       pat_a  [NUM_REQ];
   logic [1:0]       mode_a [NUM_REQ];
   logic [DUR_W-1:0] dur_a  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign pat_a[g]  = req_pattern[4*g +: 4];
      assign mode_a[g] = req_mode[2*g +: 2];
      assign dur_a[g]  = req_dur[DUR_W*g +: DUR_W];
   end

   assign tick = (div_q == DIV_LAST);

   // Round-robin search: first valid at or above rr_ptr, then wrap to the lowest valid below it.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_pat   = '0;
      win_mode  = '0;
      win_dur   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_found && req_valid[i] && (2'(i) >= rr_ptr_q)) begin
            win_found = 1'b1;
            win_idx   = 2'(i);
            win_pat   = pat_a[i];
            win_mode  = mode_a[i];
            win_dur   = dur_a[i];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_found && req_valid[i]) begin
            win_found = 1'b1;
            win_idx   = 2'(i);
            win_pat   = pat_a[i];
            win_mode  = mode_a[i];
            win_dur   = dur_a[i];
         end
      end
   end

   assign win_next = (win_idx == 2'(NUM_REQ - 1)) ? 2'd0 : win_idx + 2'd1;

   // Handshake: a request transfers in the cycle req_valid[i] && req_ready[i]; ready is combinational,
   // only asserted in IDLE for the round-robin winner, and requesters hold valid/payload until then.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = (state_q == ST_IDLE) && win_found && (win_idx == 2'(i)) && req_valid[i];
      end
   end

   assign accept = |(req_valid & req_ready);

   always_comb begin
      state_d    = state_q;
      div_d      = tick ? '0 : div_q + 1'b1;
      idle_rot_d = idle_rot_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      cur_pat_d  = cur_pat_q;
      cur_mode_d = cur_mode_q;
      dur_cnt_d  = dur_cnt_q;
      blank_d    = blank_q;

      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               idle_rot_d = {idle_rot_q[2:0], idle_rot_q[3]};
            end
            if (accept) begin
               state_d    = ST_SHOW;
               div_d      = '0;
               cur_pat_d  = win_pat;
               cur_mode_d = mode_e'(win_mode);
               dur_cnt_d  = (win_dur == '0) ? DUR_W'(1) : win_dur;
               blank_d    = 1'b0;
               grant_id_d = win_idx;
               rr_ptr_d   = win_next;
            end
         end
         ST_SHOW: begin
            if (tick) begin
               dur_cnt_d = dur_cnt_q - 1'b1;
               if (dur_cnt_q == DUR_W'(1)) begin
                  state_d = ST_IDLE;
               end else begin
                  case (cur_mode_q)
                     MODE_CW:    cur_pat_d = {cur_pat_q[2:0], cur_pat_q[3]};
                     MODE_CCW:   cur_pat_d = {cur_pat_q[0], cur_pat_q[3:1]};
                     MODE_BLINK: blank_d   = ~blank_q;
                     default:    cur_pat_d = cur_pat_q;
                  endcase
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         idle_rot_q <= 4'b0001;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         cur_pat_q  <= '0;
         cur_mode_q <= MODE_STATIC;
         dur_cnt_q  <= '0;
         blank_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         idle_rot_q <= idle_rot_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         cur_pat_q  <= cur_pat_d;
         cur_mode_q <= cur_mode_d;
         dur_cnt_q  <= dur_cnt_d;
         blank_q    <= blank_d;
      end
   end

   // busy mirrors the FSM state (high exactly in SHOW) and doubles as its observation point.
   assign busy     = (state_q == ST_SHOW);
   assign led_pwr  = busy;
   assign led      = busy ? (blank_q ? 4'b0000 : cur_pat_q) : idle_rot_q;
   assign grant_id = grant_id_q;

endmodule
